// File: rtl/rf_value_change_recorder.sv
// rtl/rf_value_change_recorder.sv - per-cycle value-change detector feeding a timestamped record FIFO
module rf_vcr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full, do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_req & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign rdata   = empty ? '0 : mem[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end
endmodule

module rf_value_change_recorder #(
  parameter int NUM_VARS   = 8,
  parameter int VALUE_W    = 32,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int IDX_W     = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_VARS-1:0]           watch_mask,
  input  logic [NUM_VARS*VALUE_W-1:0]   var_values,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [IDX_W-1:0]              rec_index,
  output logic [VALUE_W-1:0]            rec_value,
  output logic [TS_W-1:0]               rec_time,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [15:0]                   dropped_count,
  output logic                          busy
);
  localparam int REC_W = IDX_W + VALUE_W + TS_W;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                        state_q, state_d;
  logic                          primed_q, primed_d;
  logic [TS_W-1:0]               ts_q, ts_d, snap_ts_q, snap_ts_d;
  logic [NUM_VARS*VALUE_W-1:0]   shadow_q, shadow_d, snap_q, snap_d;
  logic [NUM_VARS-1:0]           pend_q, pend_d;
  logic                          overflow_q, overflow_d;
  logic [15:0]                   dropped_q, dropped_d;

  logic [NUM_VARS-1:0]           chg, scan_hot;
  logic [IDX_W-1:0]              scan_idx;
  logic [VALUE_W-1:0]            scan_val;
  logic                          push, drop, empty;
  logic [REC_W-1:0]              head;

  rf_vcr_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   ({scan_idx, scan_val, snap_ts_q}),
    .pop_req (rec_ready),
    .rdata   (head),
    .empty   (empty),
    .drop    (drop)
  );

  always_comb begin
    chg      = '0;
    scan_hot = '0;
    scan_idx = '0;
    scan_val = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      chg[i] = watch_mask[i] &&
               (var_values[i*VALUE_W +: VALUE_W] != shadow_q[i*VALUE_W +: VALUE_W]);
    end
    // Descending walk so the lowest pending index is the one left selected.
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        scan_hot    = '0;
        scan_hot[i] = 1'b1;
        scan_idx    = IDX_W'(i);
        scan_val    = snap_q[i*VALUE_W +: VALUE_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    primed_d   = primed_q;
    ts_d       = ts_q + TS_W'(1);
    snap_ts_d  = snap_ts_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    pend_d     = pend_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        shadow_d = var_values;
        primed_d = 1'b1;
        if (primed_q && enable && (chg != '0)) begin
          snap_d    = var_values;
          pend_d    = chg;
          snap_ts_d = ts_q;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        push   = 1'b1;
        pend_d = pend_q & ~scan_hot;
        if (pend_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_overflow) begin
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      primed_q   <= 1'b0;
      ts_q       <= '0;
      snap_ts_q  <= '0;
      shadow_q   <= '0;
      snap_q     <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      primed_q   <= primed_d;
      ts_q       <= ts_d;
      snap_ts_q  <= snap_ts_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  assign rec_valid     = ~empty;
  assign rec_index     = head[REC_W-1 -: IDX_W];
  assign rec_value     = head[TS_W +: VALUE_W];
  assign rec_time      = head[TS_W-1:0];
  assign overflow      = overflow_q;
  assign dropped_count = dropped_q;
  assign busy          = (state_q == SCAN);
endmodule

// File: tb/tb_rf_value_change_recorder.sv
// tb/tb_rf_value_change_recorder.sv - directed table and sequence checks for rf_value_change_recorder
module tb_rf_value_change_recorder;
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [7:0]    watch_mask;
  logic [255:0]  var_values;
  logic          rec_valid;
  logic          rec_ready;
  logic [2:0]    rec_index;
  logic [31:0]   rec_value;
  logic [31:0]   rec_time;
  logic          overflow;
  logic          clear_overflow;
  logic [15:0]   dropped_count;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] tb_ts;

  rf_value_change_recorder dut (
    .clk(clk), .rst(rst), .enable(enable), .watch_mask(watch_mask),
    .var_values(var_values), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_index(rec_index), .rec_value(rec_value), .rec_time(rec_time),
    .overflow(overflow), .clear_overflow(clear_overflow),
    .dropped_count(dropped_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference timestamp: edges seen since the last reset.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  typedef struct {
    int          vidx;
    logic [31:0] val;
    logic [7:0]  mask;
    logic        en;
    logic        exp;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_var(input int i, input logic [31:0] v);
    var_values[i*32 +: 32] = v;
  endtask

  task automatic expect_rec(input string nm, input int idx, input logic [31:0] val,
                            input logic [31:0] t);
    chk({nm, ".valid"}, 64'(rec_valid), 64'd1);
    chk({nm, ".index"}, 64'(rec_index), 64'(idx));
    chk({nm, ".value"}, 64'(rec_value), 64'(val));
    chk({nm, ".time"},  64'(rec_time),  64'(t));
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  logic [31:0] t0, t1;
  logic [31:0] tsn[20];

  initial begin
    rst = 1'b1; enable = 1'b1; watch_mask = 8'hFF; var_values = '0;
    rec_ready = 1'b0; clear_overflow = 1'b0;
    tbl[0] = '{4, 32'h11,       8'hFF, 1'b1, 1'b1};
    tbl[1] = '{4, 32'h22,       8'hEF, 1'b1, 1'b0};
    tbl[2] = '{4, 32'h22,       8'hFF, 1'b1, 1'b0};
    tbl[3] = '{5, 32'h33,       8'hFF, 1'b0, 1'b0};
    tbl[4] = '{5, 32'h33,       8'hFF, 1'b1, 1'b0};
    tbl[5] = '{7, 32'hFFFFFFFF, 8'hFF, 1'b1, 1'b1};
    tbl[6] = '{0, 32'hDEAD,     8'h01, 1'b1, 1'b1};

    do_reset(2);
    chk("rst.valid",    64'(rec_valid), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    chk("rst.dropped",  64'(dropped_count), 64'd0);
    chk("rst.busy",     64'(busy), 64'd0);
    chk("rst.head",     {rec_index, rec_value, rec_time}, 64'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("quiet%0d.valid", c), 64'({rec_valid, busy}), 64'd0);
    end

    do_reset(1);
    repeat (5) tick();
    set_var(2, 32'hA5);
    tick(); tick();
    expect_rec("ts5", 2, 32'hA5, 32'd5);
    chk("ts5.drained", 64'(rec_valid), 64'd0);

    for (int v = 0; v < 7; v++) begin
      watch_mask = tbl[v].mask;
      enable     = tbl[v].en;
      set_var(tbl[v].vidx, tbl[v].val);
      t0 = tb_ts;
      tick(); tick();
      chk($sformatf("tbl%0d.valid", v), 64'(rec_valid), 64'(tbl[v].exp));
      if (rec_valid && tbl[v].exp)
        expect_rec($sformatf("tbl%0d", v), tbl[v].vidx, tbl[v].val, t0);
      chk($sformatf("tbl%0d.drained", v), 64'(rec_valid), 64'd0);
    end
    enable = 1'b1;

    watch_mask = 8'hBF;
    set_var(0, 32'd1); set_var(3, 32'd7); set_var(6, 32'd9);
    t0 = tb_ts;
    tick(); chk("mask.busy1", 64'(busy), 64'd1);
    tick(); chk("mask.busy2", 64'(busy), 64'd1);
    tick(); chk("mask.busy3", 64'(busy), 64'd0);
    expect_rec("mask.r0", 0, 32'd1, t0);
    expect_rec("mask.r1", 3, 32'd7, t0);
    watch_mask = 8'hFF;
    repeat (3) tick();
    chk("mask.no_var6", 64'(rec_valid), 64'd0);

    for (int n = 0; n < 20; n++) begin
      set_var(1, 32'd100 + 32'(n));
      tsn[n] = tb_ts;
      repeat (3) tick();
    end
    chk("ovf.flag",    64'(overflow), 64'd1);
    chk("ovf.dropped", 64'(dropped_count), 64'd4);
    for (int n = 0; n < 16; n++)
      expect_rec($sformatf("ovf.r%0d", n), 1, 32'd100 + 32'(n), tsn[n]);
    chk("ovf.drained", 64'(rec_valid), 64'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf.cleared", 64'({overflow, dropped_count}), 64'd0);

    set_var(0, 32'h50); set_var(2, 32'h52); set_var(4, 32'h54); set_var(5, 32'h55);
    t0 = tb_ts;
    tick();
    set_var(1, 32'd1); tick();
    set_var(1, 32'd2); tick();
    set_var(1, 32'd3); tick();
    tick();
    t1 = tb_ts;
    tick(); tick();
    expect_rec("coal.r0", 0, 32'h50, t0);
    expect_rec("coal.r1", 2, 32'h52, t0);
    expect_rec("coal.r2", 4, 32'h54, t0);
    expect_rec("coal.r3", 5, 32'h55, t0);
    expect_rec("coal.r4", 1, 32'd3, t1);
    chk("coal.drained", 64'(rec_valid), 64'd0);

    set_var(2, 32'h62); set_var(3, 32'h63); set_var(4, 32'h64); set_var(5, 32'h65);
    tick();
    rec_ready = 1'($urandom_range(0, 1));
    tick();
    rec_ready = 1'($urandom_range(0, 1));
    #2 rst = 1'b1;
    #1;
    chk("arst.outs", 64'({rec_valid, busy, overflow, dropped_count}), 64'd0);
    chk("arst.head", {rec_index, rec_value, rec_time}, 64'd0);
    tick();
    rec_ready = 1'($urandom_range(0, 1));
    rst = 1'b0;
    repeat (3) tick();
    rec_ready = 1'b0;
    chk("arst.quiet", 64'(rec_valid), 64'd0);
    set_var(7, 32'h77);
    tick(); tick();
    expect_rec("arst.first", 7, 32'h77, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_value_change_recorder.md
Name: rf_value_change_recorder

Overview:
- Hardware-side value-change recorder feeding the reflection layer's variable/value objects.
- Watches NUM_VARS design variables and detects per-cycle changes.
- Serialises each change into a timestamped record (index, value, time) and buffers it in a FIFO.
- The simulation-side reflection manager drains the FIFO over a valid/ready handshake.

Parameters:
- NUM_VARS, 8, number of watched variables (1..32); IDX_W = max(1, clog2(NUM_VARS)).
- VALUE_W, 32, width of each watched variable.
- TS_W, 32, timestamp counter width.
- FIFO_DEPTH, 16, record FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  capture enable.
- watch_mask  in  NUM_VARS  per-variable watch enable.
- var_values  in  NUM_VARS*VALUE_W  packed variables; index i at [i*VALUE_W +: VALUE_W].
- rec_valid  out  1  FIFO non-empty.
- rec_ready  in  1  consumer accepts the head record.
- rec_index  out  IDX_W  head record variable index.
- rec_value  out  VALUE_W  head record value.
- rec_time  out  TS_W  head record timestamp.
- overflow  out  1  sticky flag: a record was dropped.
- clear_overflow  in  1  clears overflow and dropped_count.
- dropped_count  out  16  saturating count of dropped records.
- busy  out  1  high while in SCAN.

Behaviour:
- Reset (async assert, sync release): rec_valid=0, overflow=0, dropped_count=0, busy=0, ts=0, FIFO empty, state=IDLE, primed=0, shadow=0. rec_index/value/time=0 while empty.
- ts increments every edge and wraps modulo 2^TS_W.
- Priming:
  - The first edge after reset release loads shadow<=var_values, sets primed=1, and emits nothing.
  - While enable=0, shadow<=var_values every edge in IDLE, so re-enabling never reports stale changes.
- IDLE, primed and enable=1:
  - chg = (var_values != shadow) & watch_mask, per variable.
  - If chg≠0: snap<=var_values, pend<=chg, snap_ts<=ts, shadow<=var_values, state<=SCAN.
  - Unmasked variables update shadow without being reported.
- SCAN:
  - Each edge handles the lowest set bit k of pend: push {k, snap[k], snap_ts} and clear pend[k].
  - When the cleared bit is the last one, state<=IDLE.
  - Shadow is frozen during SCAN. Changes during SCAN are reported at the next IDLE edge with the then-current value; intermediate values are coalesced.
  - Minimum gap between capture events = popcount(chg)+1 edges.
  - enable falling during SCAN does not abort; the scan completes.
- Latency: a change sampled at edge E produces its first record written at E+1, with rec_valid high after E+1. rec_time is the ts value at E. All records of one event share rec_time.
- FIFO (first-word-fall-through):
  - Pop occurs on rec_valid & rec_ready.
  - Push is accepted if not full, or if full with a pop in the same edge.
  - Pop when empty is ignored. Simultaneous push and pop on an empty FIFO: push lands, no pop.
- Drop:
  - A push refused because the FIFO is full discards the record; the pend bit is still cleared, so the scan never stalls.
  - On a drop: overflow<=1 and dropped_count increments, saturating at 16'hFFFF.
  - clear_overflow has priority over a same-edge drop: the result is overflow=0, count=0.
- rst asserted mid-SCAN or with a non-empty FIFO: all state is discarded immediately and priming repeats.

Test Plan:
- Reset, hold var_values constant for 10 cycles, enable=1 → no records; the priming edge produces no record.
- ts=5 at edge E, var[2]: 0→0xA5, mask=0xFF → after E+1 one record {2, 0xA5, 5}; rec_valid drops after the pop.
- Same edge, var[0]=1, var[3]=7, var[6]=9 with mask=0xBF → exactly two records in order idx0, idx3, same rec_time; busy high for 2 cycles; var[6] is not reported and a later unchanged var[6] produces no record.
- FIFO_DEPTH=16, rec_ready=0, 20 single-variable changes spaced 3 cycles apart → 16 records retained in order, overflow=1, dropped_count=4; clear_overflow pulse → 0/0.
- var[1] changes 1→2→3 on consecutive edges during a 4-bit scan → one later record for var[1] with value 3.
- rec_ready toggled pseudo-randomly, with rst pulsed mid-SCAN for 1 cycle → outputs return to 0 asynchronously; the first post-reset change is reported with ts counted from 0.
